// File: rtl/multi_cycle_add_sub_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_add_sub_if
// Request/response bundle for the slice-serial adder/subtractor.
//   start     : request, honoured only while ready is high
//   x, y      : operands, sampled on the accept edge
//   opcode    : 0 = x + y, 1 = x - y, sampled on the accept edge
//   ready     : engine idle and able to accept start
//   done      : one-cycle pulse, result fields valid
//   sum       : WIDTH-bit result (modulo 2^WIDTH)
//   carry_out : carry out of the MSB (subtract: 1 = no borrow)
//   overflow  : signed overflow
//   zero      : sum == 0
// master = requester (ALU issue side), slave = the engine itself.
// -----------------------------------------------------------------------------
interface multi_cycle_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             opcode;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, x, y, opcode,
        input  ready, done, sum, carry_out, overflow, zero
    );

    modport slave (
        input  start, x, y, opcode,
        output ready, done, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/multi_cycle_add_sub.sv
// -----------------------------------------------------------------------------
// multi_cycle_add_sub
// Slice-serial two's-complement adder/subtractor. SLICE bits are added per
// clock, LSB slice first, so a WIDTH-bit result is produced after
// NS = WIDTH/SLICE RUN cycles without a full-width carry chain.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : slave side of multi_cycle_add_sub_if (start/ready/done handshake,
//           operands, result and flags)
// Result and flags are registered and change only on the completion edge.
// -----------------------------------------------------------------------------
module multi_cycle_add_sub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_cycle_add_sub_if.slave bus
);
    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("multi_cycle_add_sub: need WIDTH >= 2, 1 <= SLICE <= WIDTH, WIDTH multiple of SLICE");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted right one slice per RUN cycle
    logic [WIDTH-1:0] b_q, b_d;       // operand B (pre-inverted for subtract), shifted likewise
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;   // partial result, filled from the top and shifted down
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic [SLICE-1:0] sl_sum_s;
    logic             sl_cout_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] res_next_s;

    // Add the current (lowest) slice and form the next partial result.
    always_comb begin
        a_sl_s                 = a_q[SLICE-1:0];
        b_sl_s                 = b_q[SLICE-1:0];
        {sl_cout_s, sl_sum_s}  = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from sum = a ^ b ^ cin; for
        // SLICE = 1 this is exactly the incoming carry register.
        msb_cin_s              = sl_sum_s[SLICE-1] ^ a_sl_s[SLICE-1] ^ b_sl_s[SLICE-1];
        // New slice enters at the top; after NS cycles slice 0 sits at the LSB.
        res_next_s             = (res_q >> SLICE) | (WIDTH'(sl_sum_s) << (WIDTH - SLICE));
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.x;
                    // Subtract as x + ~y + 1: invert B here, seed carry with 1.
                    b_d     = bus.y ^ {WIDTH{bus.opcode}};
                    carry_d = bus.opcode;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = sl_cout_s;
                cnt_d   = cnt_q + CW'(1);
                res_d   = res_next_s;
                if (cnt_q == CW'(NS - 1)) begin
                    state_d = ST_IDLE;
                    sum_d   = res_next_s;
                    cout_d  = sl_cout_s;
                    ovf_d   = msb_cin_s ^ sl_cout_s;
                    zero_d  = (res_next_s == {WIDTH{1'b0}});
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;

endmodule
